// File: rtl/mm_pkg.sv
// Shared definitions for the matrix-multiply loop sequencer.
package mm_pkg;

  localparam int unsigned MM_IDX_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } mm_state_e;

endpackage

// File: rtl/mm_idx_counter.sv
// Loadable wrapping index counter: clears to 0, steps on inc, wraps after 'last'.
module mm_idx_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] last,
  output logic [W-1:0] value,
  output logic         wrap
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign value = cnt_q;
  assign wrap  = inc && (cnt_q == last);

  // Next count: clear has priority, otherwise step and wrap at the bound.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = (cnt_q == last) ? '0 : cnt_q + W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mm_loop_sequencer.sv
// Triple-loop index sequencer for a MAC datapath (k innermost, then j, then i).
// Optional feature: define MM_SEQ_PERF_CNT_EN to add the perf_cycles output.
module mm_loop_sequencer
  import mm_pkg::*;
#(
  parameter int unsigned IDX_W = MM_IDX_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      cfg_m,
  input  logic [31:0]      cfg_k,
  input  logic [31:0]      cfg_n,
  input  logic             start,
  output logic             done,
  output logic             busy,
  output logic             cfg_err,
  output logic             idx_valid,
  input  logic             idx_ready,
  output logic [IDX_W-1:0] idx_i,
  output logic [IDX_W-1:0] idx_j,
  output logic [IDX_W-1:0] idx_k,
  output logic             idx_first_k,
  output logic             idx_last_k
`ifdef MM_SEQ_PERF_CNT_EN
  ,
  output logic [31:0]      perf_cycles
`endif
);

  // A dimension is legal when 1 <= d <= 2**IDX_W, i.e. d-1 fits in IDX_W bits.
  function automatic logic dim_ok(input logic [31:0] d);
    logic [31:0] dm1;
    dm1 = d - 32'd1;
    return (d != 32'd0) && ((dm1 >> IDX_W) == 32'd0);
  endfunction

  // Bounds are stored as last index (d-1) so a full 2**IDX_W range still fits.
  function automatic logic [IDX_W-1:0] dim_last(input logic [31:0] d);
    logic [31:0] dm1;
    dm1 = d - 32'd1;
    return dm1[IDX_W-1:0];
  endfunction

  mm_state_e        state_q, state_d;
  logic             cfg_err_q, cfg_err_d;
  logic [IDX_W-1:0] m_last_q, m_last_d;
  logic [IDX_W-1:0] k_last_q, k_last_d;
  logic [IDX_W-1:0] n_last_q, n_last_d;
  logic             clr;

  logic fire;
  logic k_inc, j_inc, i_inc;
  logic k_wrap, j_wrap, i_wrap;
  logic final_beat;

  assign idx_valid  = (state_q == ST_RUN);
  assign done       = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign cfg_err    = cfg_err_q;

  assign fire       = idx_valid && idx_ready;
  assign k_inc      = fire;
  assign j_inc      = k_inc && k_wrap;
  assign i_inc      = j_inc && j_wrap;
  assign final_beat = i_inc && i_wrap;

  assign idx_first_k = (idx_k == '0);
  assign idx_last_k  = (idx_k == k_last_q);

  mm_idx_counter #(.W(IDX_W)) u_cnt_k (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (k_inc),
    .last  (k_last_q),
    .value (idx_k),
    .wrap  (k_wrap)
  );

  mm_idx_counter #(.W(IDX_W)) u_cnt_j (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (j_inc),
    .last  (n_last_q),
    .value (idx_j),
    .wrap  (j_wrap)
  );

  mm_idx_counter #(.W(IDX_W)) u_cnt_i (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .inc   (i_inc),
    .last  (m_last_q),
    .value (idx_i),
    .wrap  (i_wrap)
  );

  // Next-state, config capture and error flag; config only loads on an accepted start.
  always_comb begin
    state_d   = state_q;
    cfg_err_d = cfg_err_q;
    m_last_d  = m_last_q;
    k_last_d  = k_last_q;
    n_last_d  = n_last_q;
    clr       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          clr      = 1'b1;
          m_last_d = dim_last(cfg_m);
          k_last_d = dim_last(cfg_k);
          n_last_d = dim_last(cfg_n);
          if (dim_ok(cfg_m) && dim_ok(cfg_k) && dim_ok(cfg_n)) begin
            cfg_err_d = 1'b0;
            state_d   = ST_RUN;
          end else begin
            cfg_err_d = 1'b1;
            state_d   = ST_DONE;
          end
        end
      end
      ST_RUN: begin
        if (final_beat) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and configuration registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cfg_err_q <= 1'b0;
      m_last_q  <= '0;
      k_last_q  <= '0;
      n_last_q  <= '0;
    end else begin
      state_q   <= state_d;
      cfg_err_q <= cfg_err_d;
      m_last_q  <= m_last_d;
      k_last_q  <= k_last_d;
      n_last_q  <= n_last_d;
    end
  end

`ifdef MM_SEQ_PERF_CNT_EN
  logic [31:0] perf_q, perf_d;

  assign perf_cycles = perf_q;

  // RUN-cycle counter: cleared on accepted start, saturating, frozen outside RUN.
  always_comb begin
    perf_d = perf_q;
    if ((state_q == ST_IDLE) && start) begin
      perf_d = '0;
    end else if ((state_q == ST_RUN) && (perf_q != '1)) begin
      perf_d = perf_q + 32'd1;
    end
  end

  // Performance counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end
`endif

endmodule

// File: tb/tb_mm_loop_sequencer.sv
// Directed scoreboard bench for mm_loop_sequencer.
module tb_mm_loop_sequencer;

  localparam int unsigned W = 16;

  typedef struct {
    logic [W-1:0] i;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic         first;
    logic         last;
  } beat_t;

  logic         clk;
  logic         rst_n;
  logic [31:0]  cfg_m, cfg_k, cfg_n;
  logic         start;
  logic         done, busy, cfg_err, idx_valid, idx_ready;
  logic [W-1:0] idx_i, idx_j, idx_k;
  logic         idx_first_k, idx_last_k;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  beat_t       sb_q[$];

  mm_loop_sequencer #(.IDX_W(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cfg_m       (cfg_m),
    .cfg_k       (cfg_k),
    .cfg_n       (cfg_n),
    .start       (start),
    .done        (done),
    .busy        (busy),
    .cfg_err     (cfg_err),
    .idx_valid   (idx_valid),
    .idx_ready   (idx_ready),
    .idx_i       (idx_i),
    .idx_j       (idx_j),
    .idx_k       (idx_k),
    .idx_first_k (idx_first_k),
    .idx_last_k  (idx_last_k)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, ".done"},  {31'd0, done},      32'd0);
    chk({tag, ".busy"},  {31'd0, busy},      32'd0);
    chk({tag, ".valid"}, {31'd0, idx_valid}, 32'd0);
    chk({tag, ".i"},     {16'd0, idx_i},     32'd0);
    chk({tag, ".j"},     {16'd0, idx_j},     32'd0);
    chk({tag, ".k"},     {16'd0, idx_k},     32'd0);
  endtask

  // mode 0: ready always high; mode 1: ready toggles 1,0,1,0...
  // poke: re-issue start and change cfg_m mid-run; abort_at: reset after that many beats.
  task automatic run(input int unsigned m, input int unsigned k, input int unsigned n,
                     input int unsigned mode, input bit poke, input int unsigned abort_at);
    beat_t        e;
    bit           held;
    logic [W-1:0] hi, hj, hk;
    int unsigned  cyc, beats;
    bit           rdy;
    sb_q.delete();
    for (int unsigned a = 0; a < m; a++)
      for (int unsigned b = 0; b < n; b++)
        for (int unsigned c = 0; c < k; c++) begin
          e.i = W'(a); e.j = W'(b); e.k = W'(c);
          e.first = (c == 0); e.last = (c == k - 1);
          sb_q.push_back(e);
        end
    @(negedge clk);
    cfg_m = m; cfg_k = k; cfg_n = n; start = 1'b1; idx_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("start.busy", {31'd0, busy}, 32'd1);
    chk("start.err",  {31'd0, cfg_err}, 32'd0);
    held = 1'b0; cyc = 0; beats = 0;
    hi = '0; hj = '0; hk = '0;
    while (sb_q.size() > 0 && cyc < 200) begin
      rdy = (mode == 0) ? 1'b1 : (cyc % 2 == 0);
      idx_ready = rdy;
      if (poke && cyc == 1) begin start = 1'b1; cfg_m = 32'd5; end
      if (poke && cyc == 2) start = 1'b0;
      chk("beat.valid", {31'd0, idx_valid}, 32'd1);
      chk("beat.done",  {31'd0, done}, 32'd0);
      if (held) begin
        chk("stall.i", {16'd0, idx_i}, {16'd0, hi});
        chk("stall.j", {16'd0, idx_j}, {16'd0, hj});
        chk("stall.k", {16'd0, idx_k}, {16'd0, hk});
      end
      if (rdy) begin
        e = sb_q.pop_front();
        chk("beat.i", {16'd0, idx_i}, {16'd0, e.i});
        chk("beat.j", {16'd0, idx_j}, {16'd0, e.j});
        chk("beat.k", {16'd0, idx_k}, {16'd0, e.k});
        chk("beat.first_k", {31'd0, idx_first_k}, {31'd0, e.first});
        chk("beat.last_k",  {31'd0, idx_last_k},  {31'd0, e.last});
        beats++;
        held = 1'b0;
      end else begin
        held = 1'b1; hi = idx_i; hj = idx_j; hk = idx_k;
      end
      @(negedge clk);
      cyc++;
      if (abort_at != 0 && beats == abort_at) begin
        rst_n = 1'b0;
        #1;
        chk_idle_zero("rst_mid");
        chk("rst_mid.err", {31'd0, cfg_err}, 32'd0);
        @(negedge clk);
        chk("rst_mid.nodone", {31'd0, done}, 32'd0);
        rst_n = 1'b1;
        idx_ready = 1'b0;
        sb_q.delete();
        return;
      end
    end
    chk("run.timeout", cyc < 200 ? 32'd1 : 32'd0, 32'd1);
    chk("end.valid", {31'd0, idx_valid}, 32'd0);
    chk("end.done",  {31'd0, done}, 32'd1);
    chk("end.busy",  {31'd0, busy}, 32'd1);
    idx_ready = 1'b0;
    @(negedge clk);
    chk("post.done",  {31'd0, done}, 32'd0);
    chk("post.busy",  {31'd0, busy}, 32'd0);
    chk("post.valid", {31'd0, idx_valid}, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; idx_ready = 1'b0;
    cfg_m = '0; cfg_k = '0; cfg_n = '0;
    #1;
    chk_idle_zero("reset");
    chk("reset.err", {31'd0, cfg_err}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // 2x3x2 back-to-back
    run(2, 3, 2, 0, 1'b0, 0);
    // 1x1x1 single beat
    run(1, 1, 1, 0, 1'b0, 0);
    // 2x2x2 with ready toggling
    run(2, 2, 2, 1, 1'b0, 0);

    // k=0 configuration error
    @(negedge clk);
    cfg_m = 2; cfg_k = 0; cfg_n = 2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("err.valid", {31'd0, idx_valid}, 32'd0);
    chk("err.done",  {31'd0, done}, 32'd1);
    chk("err.flag",  {31'd0, cfg_err}, 32'd1);
    @(negedge clk);
    chk("err.post_done", {31'd0, done}, 32'd0);
    chk("err.sticky",    {31'd0, cfg_err}, 32'd1);
    chk("err.post_busy", {31'd0, busy}, 32'd0);

    // oversize dimension (2**W + 1) also errors; 2**W exactly would be legal
    @(negedge clk);
    cfg_m = 32'h0001_0001; cfg_k = 1; cfg_n = 1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("big.valid", {31'd0, idx_valid}, 32'd0);
    chk("big.flag",  {31'd0, cfg_err}, 32'd1);
    @(negedge clk);

    // valid run clears the error (checked inside run at start)
    run(1, 2, 1, 0, 1'b0, 0);

    // mid-run start and cfg_m change ignored
    run(3, 1, 1, 0, 1'b1, 0);

    // reset after 5th beat of 2x2x2, then fresh 1x1x1
    run(2, 2, 2, 0, 1'b0, 5);
    run(1, 1, 1, 0, 1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
